// File: rtl/conv_slv_narrower.sv
// Streaming 32-bit integer to OUT_W-bit vector narrower with per-beat signedness,
// saturate/wrap selection, overflow flagging and a 2-entry skid buffer.
module conv_slv_narrower #(
  parameter int OUT_W    = 8,
  parameter bit SATURATE = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      in_data,
  input  logic             in_signed,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] ovf_count
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state, next_state;

  logic signed [31:0] din_p0;
  logic [OUT_W-1:0]   cnv_data_p0;
  logic               cnv_ovf_p0;

  logic [OUT_W-1:0]   head_data_p1, tail_data_p1;
  logic               head_ovf_p1, tail_ovf_p1;

  logic accept, pop;
  logic load_head, load_tail, shift_tail;

  // Signed range holds when every bit from the sign position upward agrees.
  function automatic logic range_ovf(input logic signed [31:0] d, input logic sgn);
    logic ovf;
    if (sgn) ovf = !((&d[31:OUT_W-1]) || !(|d[31:OUT_W-1]));
    else     ovf = |d[31:OUT_W];
    return ovf;
  endfunction

  function automatic logic [OUT_W-1:0] sat_value(input logic signed [31:0] d, input logic sgn);
    logic [OUT_W-1:0] v;
    v = '1;
    if (sgn) begin
      v = d[31] ? '0 : '1;
      v[OUT_W-1] = d[31];
    end
    return v;
  endfunction

  function automatic logic [OUT_W-1:0] narrow(input logic signed [31:0] d, input logic sgn,
                                              input logic ovf);
    logic [OUT_W-1:0] v;
    v = d[OUT_W-1:0];
    if (SATURATE && ovf) v = sat_value(d, sgn);
    return v;
  endfunction

  // Stage p0: combinational conversion of the beat being offered
  assign din_p0      = in_data;
  assign cnv_ovf_p0  = range_ovf(din_p0, in_signed);
  assign cnv_data_p0 = narrow(din_p0, in_signed, cnv_ovf_p0);

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= EMPTY;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      EMPTY: if (accept) next_state = ONE;
      ONE: begin
        if (accept && !pop)      next_state = TWO;
        else if (pop && !accept) next_state = EMPTY;
      end
      TWO:     if (pop) next_state = ONE;
      default: next_state = EMPTY;
    endcase
  end

  always_comb begin
    out_valid  = (state != EMPTY);
    load_head  = ((state == EMPTY) && accept) || ((state == ONE) && accept && pop);
    load_tail  = (state == ONE) && accept && !pop;
    shift_tail = (state == TWO) && pop;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) in_ready <= 1'b1;
    else        in_ready <= (next_state != TWO);
  end

  // Stage p1: skid buffer entries; head is what the sink sees
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_data_p1 <= '0;
      head_ovf_p1  <= 1'b0;
    end else if (load_head) begin
      head_data_p1 <= cnv_data_p0;
      head_ovf_p1  <= cnv_ovf_p0;
    end else if (shift_tail) begin
      head_data_p1 <= tail_data_p1;
      head_ovf_p1  <= tail_ovf_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (load_tail) begin
      tail_data_p1 <= cnv_data_p0;
      tail_ovf_p1  <= cnv_ovf_p0;
    end
  end

  assign out_data = head_data_p1;
  assign out_ovf  = head_ovf_p1;

  // Clear and a simultaneous overflowing accept leave exactly one event counted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (clr_cnt) begin
      ovf_count <= (accept && cnv_ovf_p0) ? CNT_W'(1) : '0;
    end else if (accept && cnv_ovf_p0 && (ovf_count != '1)) begin
      ovf_count <= ovf_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_conv_slv_narrower.sv
// Bench for conv_slv_narrower: saturating, wrapping and narrow-counter instances
// share one stimulus stream and are compared against an arithmetic range model.
module tb_conv_slv_narrower;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_signed;
  logic        in_valid;
  logic        out_ready;
  logic        clr_cnt;

  logic        in_ready_s, in_ready_w, in_ready_c;
  logic [7:0]  out_data_s, out_data_w, out_data_c;
  logic        out_ovf_s, out_ovf_w, out_ovf_c;
  logic        out_valid_s, out_valid_w, out_valid_c;
  logic [15:0] ovf_count_s, ovf_count_w;
  logic [3:0]  ovf_count_c;

  int checks = 0;
  int failures = 0;

  conv_slv_narrower #(.OUT_W(8), .SATURATE(1'b1), .CNT_W(16)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_signed(in_signed),
    .in_valid(in_valid), .in_ready(in_ready_s), .out_data(out_data_s),
    .out_ovf(out_ovf_s), .out_valid(out_valid_s), .out_ready(out_ready),
    .clr_cnt(clr_cnt), .ovf_count(ovf_count_s));

  conv_slv_narrower #(.OUT_W(8), .SATURATE(1'b0), .CNT_W(16)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_signed(in_signed),
    .in_valid(in_valid), .in_ready(in_ready_w), .out_data(out_data_w),
    .out_ovf(out_ovf_w), .out_valid(out_valid_w), .out_ready(out_ready),
    .clr_cnt(clr_cnt), .ovf_count(ovf_count_w));

  conv_slv_narrower #(.OUT_W(8), .SATURATE(1'b1), .CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_signed(in_signed),
    .in_valid(in_valid), .in_ready(in_ready_c), .out_data(out_data_c),
    .out_ovf(out_ovf_c), .out_valid(out_valid_c), .out_ready(out_ready),
    .clr_cnt(clr_cnt), .ovf_count(ovf_count_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] data;
    logic        sgn;
    logic [7:0]  sat;
    logic [7:0]  wrap;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        sgn;
  } src_t;

  typedef struct {
    logic [7:0] sat;
    logic [7:0] wrap;
    logic       ovf;
  } exp_t;

  src_t src_q[$];
  exp_t exp_q[$];
  int   npop;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] d, input logic sgn);
    exp_t   e;
    longint v, lo, hi, s;
    v  = sgn ? longint'($signed(d)) : longint'({32'd0, d});
    lo = sgn ? -128 : 0;
    hi = sgn ? 127 : 255;
    e.ovf  = (v < lo) || (v > hi);
    s      = (v < lo) ? lo : ((v > hi) ? hi : v);
    e.sat  = s[7:0];
    e.wrap = d[7:0];
    return e;
  endfunction

  // One clock of a well-behaved source and sink; handshakes are judged in the low phase.
  task automatic step(input logic vld, input logic rdy);
    exp_t e;
    @(negedge clk);
    in_valid  = vld && (src_q.size() > 0);
    in_data   = (src_q.size() > 0) ? src_q[0].data : 32'd0;
    in_signed = (src_q.size() > 0) ? src_q[0].sgn : 1'b0;
    out_ready = rdy;
    #1;
    if (out_valid_s && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 64'(out_data_s), 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        chk("stream_sat_data", 64'(out_data_s), 64'(e.sat));
        chk("stream_wrap_data", 64'(out_data_w), 64'(e.wrap));
        chk("stream_ovf", 64'({out_ovf_s, out_ovf_w, out_ovf_c}), 64'({3{e.ovf}}));
        npop++;
      end
    end
    if (in_valid && in_ready_s) begin
      exp_q.push_back(model(src_q[0].data, src_q[0].sgn));
      void'(src_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      step(1'b1, 1'b1);
      n++;
    end
    if (src_q.size() > 0 || exp_q.size() > 0) chk("drain_timeout", 64'(n), 64'(budget + 1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    src_q.delete();
    exp_q.delete();
  endtask

  vec_t vecs[12];
  int   exp_ovf_cnt;
  int   ncyc;
  src_t s;

  initial begin
    rst_n = 1'b0; in_data = '0; in_signed = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; clr_cnt = 1'b0; npop = 0;

    vecs[0]  = '{32'h0000007F, 1'b1, 8'h7F, 8'h7F, 1'b0};
    vecs[1]  = '{32'h000000FF, 1'b1, 8'h7F, 8'hFF, 1'b1};
    vecs[2]  = '{32'hFFFFFFFF, 1'b1, 8'hFF, 8'hFF, 1'b0};
    vecs[3]  = '{32'hFFFFFF00, 1'b1, 8'h80, 8'h00, 1'b1};
    vecs[4]  = '{32'h000000FF, 1'b0, 8'hFF, 8'hFF, 1'b0};
    vecs[5]  = '{32'h00000100, 1'b0, 8'hFF, 8'h00, 1'b1};
    vecs[6]  = '{32'h00001234, 1'b0, 8'hFF, 8'h34, 1'b1};
    vecs[7]  = '{32'hFFFFFF80, 1'b1, 8'h80, 8'h80, 1'b0};
    vecs[8]  = '{32'h80000000, 1'b1, 8'h80, 8'h00, 1'b1};
    vecs[9]  = '{32'hFFFFFFFF, 1'b0, 8'hFF, 8'hFF, 1'b1};
    vecs[10] = '{32'h00000080, 1'b0, 8'h80, 8'h80, 1'b0};
    vecs[11] = '{32'hFFFFFF7F, 1'b1, 8'h80, 8'h7F, 1'b1};

    do_reset();
    chk("reset_out_valid", 64'({out_valid_s, out_valid_w, out_valid_c}), 64'd0);
    chk("reset_in_ready", 64'({in_ready_s, in_ready_w, in_ready_c}), 64'b111);
    chk("reset_out_data", 64'({out_data_s, out_data_w, out_ovf_s}), 64'd0);
    chk("reset_ovf_count", 64'({ovf_count_s, ovf_count_c}), 64'd0);

    // Table vectors streamed back to back: each beat is visible one edge after acceptance.
    exp_ovf_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_data = vecs[i].data; in_signed = vecs[i].sgn; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1;
      if (vecs[i].ovf) exp_ovf_cnt++;
      chk($sformatf("vec%0d_valid", i), 64'({out_valid_s, in_ready_s}), 64'b11);
      chk($sformatf("vec%0d_sat", i), 64'({out_data_s, out_ovf_s}), 64'({vecs[i].sat, vecs[i].ovf}));
      chk($sformatf("vec%0d_wrap", i), 64'({out_data_w, out_ovf_w}), 64'({vecs[i].wrap, vecs[i].ovf}));
      chk($sformatf("vec%0d_cnt", i), 64'(ovf_count_s), 64'(exp_ovf_cnt));
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("table_drained", 64'(out_valid_s), 64'd0);
    chk("table_cnt4", 64'(ovf_count_c), 64'(exp_ovf_cnt));

    // Backpressure: two beats fill the skid buffer, the third waits at the source.
    for (int i = 1; i <= 4; i++) begin
      s.data = 32'(i); s.sgn = 1'b0; src_q.push_back(s);
    end
    step(1'b1, 1'b0);
    chk("bp_ready_after1", 64'(in_ready_s), 64'd1);
    step(1'b1, 1'b0);
    chk("bp_ready_after2", 64'(in_ready_s), 64'd0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("bp_accepted", 64'(src_q.size()), 64'd2);
    chk("bp_head_stable", 64'({out_valid_s, out_data_s}), 64'({1'b1, 8'd1}));
    npop = 0;
    drain(20);
    chk("bp_popped", 64'(npop), 64'd4);

    // Full-rate streaming of random beats in both signedness modes.
    for (int i = 0; i < 100; i++) begin
      s.sgn  = 1'($urandom_range(0, 1));
      s.data = (i % 3 == 0) ? $urandom() : (32'($urandom_range(0, 600)) - 32'd300);
      src_q.push_back(s);
    end
    npop = 0;
    ncyc = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && ncyc < 200) begin
      step(1'b1, 1'b1);
      ncyc++;
    end
    chk("stream_count", 64'(npop), 64'd100);
    chk("stream_cycles", 64'(ncyc), 64'd101);

    // Narrow counter saturation and clear interaction.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      s.data = 32'h100; s.sgn = 1'b0; src_q.push_back(s);
    end
    drain(40);
    chk("cnt4_saturated", 64'(ovf_count_c), 64'hF);
    chk("cnt16_count", 64'(ovf_count_s), 64'd17);
    s.data = 32'h100; s.sgn = 1'b0; src_q.push_back(s);
    clr_cnt = 1'b1;
    step(1'b1, 1'b1);
    clr_cnt = 1'b0;
    chk("clr_with_ovf_c", 64'(ovf_count_c), 64'd1);
    chk("clr_with_ovf_s", 64'(ovf_count_s), 64'd1);
    drain(5);
    clr_cnt = 1'b1;
    step(1'b0, 1'b1);
    clr_cnt = 1'b0;
    chk("clr_alone", 64'({ovf_count_s, ovf_count_c}), 64'd0);

    // Reset while full, with the sink ready in that same cycle.
    for (int i = 0; i < 2; i++) begin
      s.data = 32'h100; s.sgn = 1'b0; src_q.push_back(s);
    end
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("full_before_reset", 64'({in_ready_s, out_valid_s, ovf_count_s}), 64'({1'b0, 1'b1, 16'd2}));
    @(negedge clk);
    rst_n = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    chk("rst_mid_valid", 64'(out_valid_s), 64'd0);
    chk("rst_mid_ready", 64'(in_ready_s), 64'd1);
    chk("rst_mid_cnt", 64'({ovf_count_s, ovf_count_c}), 64'd0);
    s.data = 32'hFFFFFF00; s.sgn = 1'b1; src_q.push_back(s);
    npop = 0;
    drain(5);
    chk("post_reset_beat", 64'(npop), 64'd1);
    chk("post_reset_cnt", 64'(ovf_count_s), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
